// File: rtl/pedal_chain_sequencer.sv
// Per-sample scheduler for the effect-pedal chain: walks the stages in order and
// hands the running frame to each enabled stage over a shared bus.
module pedal_chain_sequencer #(
  parameter int DATA_W         = 16,
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         sample_valid,
  input  logic [DATA_W-1:0]            Signal_in,
  input  logic [NUM_STAGES-1:0]        enables,
  input  logic                         clear_flags,
  output logic [DATA_W-1:0]            stage_in,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_out,
  output logic [DATA_W-1:0]            Signal_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout_err,
  output logic [IDX_W-1:0]             timeout_stage
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, OUTPUT} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   frame;
  logic [CNT_W-1:0]    cnt;

  logic                sel_en;
  logic                sel_done;
  logic [DATA_W-1:0]   sel_out;
  logic                last_stage;
  logic                timeout_hit;

  // Only the stage currently addressed by idx is ever looked at.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    sel_en   = 1'b0;
    sel_done = 1'b0;
    sel_out  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_en   = enables[k];
        sel_done = stage_done[k];
        sel_out  = stage_out[k*DATA_W +: DATA_W];
      end
    end
  end

  assign last_stage  = (idx == IDX_W'(NUM_STAGES - 1));
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign stage_in    = frame;
  assign busy        = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      idx           <= '0;
      frame         <= '0;
      cnt           <= '0;
      stage_start   <= '0;
      Signal_out    <= '0;
      out_valid     <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
      timeout_stage <= '0;
    end else begin
      // NOTE: non-blocking throughout; every branch below sees pre-edge values.
      out_valid <= 1'b0;

      // Clear is written first so a set on the same edge overrides it.
      if (clear_flags) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (sample_valid && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_valid) begin
            frame <= Signal_in;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_en) begin
            stage_start <= NUM_STAGES'(1) << idx;
            cnt         <= '0;
            state       <= WAIT;
          end else begin
            state <= NEXT;
          end
        end
        WAIT: begin
          // A done arriving on the timeout edge still counts as a completion.
          if (sel_done) begin
            frame       <= sel_out;
            stage_start <= '0;
            state       <= NEXT;
          end else if (timeout_hit) begin
            stage_start   <= '0;
            timeout_err   <= 1'b1;
            timeout_stage <= idx;
            state         <= NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        NEXT: begin
          if (last_stage) begin
            Signal_out <= frame;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ISSUE;
          end
        end
        OUTPUT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pedal_chain_sequencer.sv
// Bench for pedal_chain_sequencer: directed scenarios plus randomized frames,
// all checked every cycle against a timeline model of the chain.
module tb_pedal_chain_sequencer;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int T  = 8;
  localparam int IW = 2;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             sample_valid;
  logic [DW-1:0]    Signal_in;
  logic [NS-1:0]    enables;
  logic             clear_flags;
  logic [DW-1:0]    stage_in;
  logic [NS-1:0]    stage_start;
  logic [NS-1:0]    stage_done = '0;
  logic [NS*DW-1:0] stage_out = '0;
  logic [DW-1:0]    Signal_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic             timeout_err;
  logic [IW-1:0]    timeout_stage;

  always #5 Clk = ~Clk;

  pedal_chain_sequencer #(.DATA_W(DW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset(Reset), .sample_valid(sample_valid), .Signal_in(Signal_in),
    .enables(enables), .clear_flags(clear_flags), .stage_in(stage_in),
    .stage_start(stage_start), .stage_done(stage_done), .stage_out(stage_out),
    .Signal_out(Signal_out), .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .timeout_stage(timeout_stage)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stage behaviour: done after dly[k] extra WAIT cycles; out = const or (in^xor)+add.
  int            dly[NS];
  logic [DW-1:0] st_xor[NS], st_add[NS], st_const[NS];
  logic          st_const_en[NS];
  logic          noise = 1'b0;
  int            rcnt[NS];

  function automatic logic [DW-1:0] xf(input int k, input logic [DW-1:0] v);
    return st_const_en[k] ? st_const[k] : (v ^ st_xor[k]) + st_add[k];
  endfunction

  always @(negedge Clk) begin
    for (int k = 0; k < NS; k++) begin
      stage_out[k*DW +: DW] = xf(k, stage_in);
      if (stage_start[k]) begin
        stage_done[k] = (rcnt[k] == dly[k]);
        rcnt[k]++;
      end else begin
        rcnt[k] = 0;
        stage_done[k] = noise && ($urandom_range(3) == 0);
      end
    end
  end

  // Timeline model: on acceptance, lay out every stage's start window and the output edge.
  int            ecnt = 0;
  int            acc = -100, idle_e = -100, out_e = -100;
  int            win_s[NS], win_e[NS];
  logic          win_to[NS];
  logic [DW-1:0] win_in[NS];
  logic [DW-1:0] m_out_val = '0, m_sig = '0, m_v;
  logic          m_ov = 1'b0, m_te = 1'b0;
  logic [IW-1:0] m_ts = '0;
  int            m_off;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc = -100; idle_e = -100; out_e = -100;
      m_sig = '0; m_ov = 1'b0; m_te = 1'b0; m_ts = '0;
      for (int k = 0; k < NS; k++) begin
        win_s[k] = -1; win_e[k] = -1; win_to[k] = 1'b0;
      end
    end else begin
      ecnt++;
      if (clear_flags) begin
        m_ov = 1'b0;
        m_te = 1'b0;
      end
      if (sample_valid) begin
        if (ecnt >= acc + 1 && ecnt <= idle_e) begin
          m_ov = 1'b1;
        end else begin
          acc = ecnt; m_v = Signal_in; m_off = 0;
          for (int k = 0; k < NS; k++) begin
            win_s[k] = -1; win_e[k] = -1; win_to[k] = 1'b0;
            if (enables[k]) begin
              win_s[k] = ecnt + m_off + 1;
              win_in[k] = m_v;
              if (dly[k] <= T - 1) begin
                win_e[k] = win_s[k] + dly[k] + 1;
                m_v = xf(k, m_v);
                m_off += dly[k] + 3;
              end else begin
                win_e[k] = win_s[k] + T;
                win_to[k] = 1'b1;
                m_off += T + 2;
              end
            end else begin
              m_off += 2;
            end
          end
          out_e = ecnt + m_off;
          idle_e = out_e + 1;
          m_out_val = m_v;
        end
      end
      for (int k = 0; k < NS; k++) begin
        if (win_to[k] && win_e[k] == ecnt) begin
          m_te = 1'b1;
          m_ts = IW'(k);
        end
      end
      if (ecnt == out_e) m_sig = m_out_val;
    end
  end

  // Per-cycle compare plus a few observation counters for the directed checks.
  logic [NS-1:0] exp_start, prev_start = '0;
  logic          exp_busy;
  int            hi_cnt[NS];
  logic [DW-1:0] seen_in[NS];
  logic [15:0]   rise_log = '0;
  int            ov_pulses = 0;

  always @(negedge Clk) begin
    if (!Reset) begin
      exp_start = '0;
      for (int k = 0; k < NS; k++) begin
        if (win_s[k] <= ecnt && ecnt < win_e[k]) begin
          exp_start[k] = 1'b1;
          check("stage_in_during_wait", stage_in, win_in[k]);
        end
      end
      exp_busy = (ecnt >= acc && ecnt < idle_e);
      check("outputs{start,busy,valid,sig,ovr,terr,tstg}",
            {stage_start, busy, out_valid, Signal_out, overrun, timeout_err, timeout_stage},
            {exp_start, exp_busy, (ecnt == out_e), m_sig, m_ov, m_te, m_ts});
      for (int k = 0; k < NS; k++) begin
        if (stage_start[k]) begin
          hi_cnt[k]++;
          seen_in[k] = stage_in;
          if (prev_start == '0) rise_log = {rise_log[11:0], 4'(k)};
        end
      end
      if (out_valid) ov_pulses++;
    end
    prev_start = stage_start;
  end

  task automatic clr_mon();
    for (int k = 0; k < NS; k++) begin
      hi_cnt[k] = 0;
      seen_in[k] = '0;
    end
    rise_log = '0;
    ov_pulses = 0;
  endtask

  task automatic send(input logic [DW-1:0] v);
    Signal_in = v;
    sample_valid = 1'b1;
    @(negedge Clk);
    sample_valid = 1'b0;
  endtask

  // Returns the number of edges after the sample edge at which out_valid was seen.
  task automatic wait_out(input bit rnd, output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      if (rnd) begin
        sample_valid = ($urandom_range(15) == 0);
        clear_flags = ($urandom_range(7) == 0);
      end
      @(negedge Clk);
      n++;
    end
    sample_valid = 1'b0;
    clear_flags = 1'b0;
    check("frame_completes", out_valid, 1'b1);
  endtask

  int n;
  int sum;

  initial begin
    sample_valid = 1'b0; Signal_in = '0; enables = '0; clear_flags = 1'b0;
    for (int k = 0; k < NS; k++) begin
      dly[k] = 0; st_xor[k] = '0; st_add[k] = '0; st_const[k] = '0; st_const_en[k] = 1'b0;
      win_s[k] = -1; win_e[k] = -1; win_to[k] = 1'b0; rcnt[k] = 0;
    end
    clr_mon();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("reset_state",
          {stage_start, busy, out_valid, Signal_out, overrun, timeout_err, timeout_stage}, '0);
    @(negedge Clk);

    // All stages bypassed.
    enables = 4'b0000; clr_mon();
    send(16'h1234);
    wait_out(1'b0, n);
    check("t1_latency", n, 8);
    check("t1_signal_out", Signal_out, 16'h1234);
    sum = hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3];
    check("t1_no_start", sum, 0);
    @(negedge Clk);
    check("t1_busy_low", busy, 1'b0);

    // Stage 0 only, done in the first WAIT cycle.
    enables = 4'b0001; clr_mon();
    st_const_en[0] = 1'b1; st_const[0] = 16'h0F0F; dly[0] = 0;
    send(16'h1234);
    wait_out(1'b0, n);
    check("t2_latency", n, 9);
    check("t2_signal_out", Signal_out, 16'h0F0F);
    check("t2_stage_in", seen_in[0], 16'h1234);
    check("t2_start_cycles", hi_cnt[0], 1);
    @(negedge Clk);

    // All enabled, stage k adds k after k extra cycles.
    enables = 4'b1111; clr_mon(); st_const_en[0] = 1'b0;
    for (int k = 0; k < NS; k++) begin
      st_add[k] = DW'(k); dly[k] = k;
    end
    send(16'd100);
    wait_out(1'b0, n);
    check("t3_signal_out", Signal_out, 16'd106);
    check("t3_latency", n, 18);
    check("t3_start_order", rise_log, 16'h0123);
    check("t3_no_flags", {overrun, timeout_err}, 2'b00);
    for (int k = 0; k < NS; k++) check("t3_start_cycles", hi_cnt[k], k + 1);
    @(negedge Clk);

    // Stage 1 hangs and is abandoned.
    enables = 4'b0010; clr_mon(); dly[1] = 255;
    send(16'h5A5A);
    wait_out(1'b0, n);
    check("t4_latency", n, 16);
    check("t4_start_cycles", hi_cnt[1], 8);
    check("t4_timeout_err", timeout_err, 1'b1);
    check("t4_timeout_stage", timeout_stage, 2'd1);
    check("t4_signal_out", Signal_out, 16'h5A5A);
    clear_flags = 1'b1;
    @(negedge Clk);
    clear_flags = 1'b0;
    check("t4_cleared", timeout_err, 1'b0);
    check("t4_stage_kept", timeout_stage, 2'd1);
    @(negedge Clk);

    // Second sample two cycles into a slow frame.
    enables = 4'b1111; clr_mon();
    for (int k = 0; k < NS; k++) dly[k] = 5;
    send(16'd100);
    @(negedge Clk);
    send(16'hBEEF);
    wait_out(1'b0, n);
    check("t5_latency", n + 2, 32);
    check("t5_signal_out", Signal_out, 16'd106);
    check("t5_overrun", overrun, 1'b1);
    repeat (5) @(negedge Clk);
    check("t5_one_pulse", ov_pulses, 1);
    clear_flags = 1'b1;
    @(negedge Clk);
    clear_flags = 1'b0;

    // Asynchronous reset while stage 2 is waiting.
    dly[0] = 0; dly[1] = 0; dly[2] = 255; dly[3] = 0;
    send(16'h0010);
    n = 0;
    while (!stage_start[2] && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("t6_reach_stage2", stage_start[2], 1'b1);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check("t6_async_reset", {stage_start, Signal_out}, '0);
    @(negedge Clk);
    Reset = 1'b0;
    check("t6_idle_after", busy, 1'b0);
    @(negedge Clk);
    dly[2] = 0;
    send(16'h0010);
    wait_out(1'b0, n);
    check("t6_signal_out", Signal_out, 16'h0016);
    @(negedge Clk);

    // Randomized frames with noisy done lines, stray samples and clears.
    noise = 1'b1;
    repeat (60) begin
      enables = NS'($urandom);
      for (int k = 0; k < NS; k++) begin
        case ($urandom_range(9))
          6:       dly[k] = T - 1;
          7:       dly[k] = T;
          8:       dly[k] = T - 2;
          9:       dly[k] = 255;
          default: dly[k] = $urandom_range(4);
        endcase
        st_xor[k] = DW'($urandom);
        st_add[k] = DW'($urandom);
        st_const_en[k] = ($urandom_range(7) == 0);
        st_const[k] = DW'($urandom);
      end
      send(DW'($urandom));
      wait_out(1'b1, n);
      @(negedge Clk);
    end
    noise = 1'b0;
    repeat (3) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
